// File: rtl/encoder4_2_pending.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | encoder4_2_pending                                                   |
// | Synchronised 4-request edge latcher with priority grant handshake.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module encoder4_2_pending #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] y,
  input  logic       E,
  output logic [1:0] w,
  output logic       valid,
  input  logic       ready,
  output logic       overflow
);

  localparam logic [0:0] S_IDLE    = 1'b0;
  localparam logic [0:0] S_PRESENT = 1'b1;

  logic [3:0] r_sync [SYNC_STAGES];
  logic [3:0] r_dly;
  logic [3:0] r_rise;
  logic [3:0] r_pend;
  logic [1:0] r_w;
  logic       r_valid;
  logic       r_ovf;
  logic [0:0] r_state;

  logic [0:0] w_state_nx;
  logic       w_load;
  logic       w_accept;
  logic [1:0] w_prio;
  logic [1:0] w_code_nx;
  logic       w_valid_nx;
  logic [3:0] w_clr;
  logic [3:0] w_pend_nx;
  logic       w_ovf_nx;
  logic [3:0] w_edge;

  assign w_edge = r_sync[SYNC_STAGES-1] & ~r_dly;

  // The detected edge is registered once more before it reaches pending,
  // which sets the request-to-valid latency at SYNC_STAGES+2 edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
      r_dly  <= '0;
      r_rise <= '0;
    end else begin
      r_sync[0] <= y;
      for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
      r_dly  <= r_sync[SYNC_STAGES-1];
      r_rise <= w_edge;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:    if (!E && (r_pend != 4'b0000)) w_state_nx = S_PRESENT;
      S_PRESENT: if (E || ready)                w_state_nx = S_IDLE;
      default:                                  w_state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    w_prio = 2'd0;
    if      (r_pend[3]) w_prio = 2'd3;
    else if (r_pend[2]) w_prio = 2'd2;
    else if (r_pend[1]) w_prio = 2'd1;

    w_load     = (r_state == S_IDLE) && !E && (r_pend != 4'b0000);
    w_accept   = (r_state == S_PRESENT) && ready && !E;
    w_code_nx  = w_load ? w_prio : r_w;
    w_valid_nx = w_load || ((r_state == S_PRESENT) && !E && !ready);
    w_clr      = w_accept ? (4'b0001 << r_w) : 4'b0000;
    // A new edge wins over the acceptance clear of the same bit.
    w_pend_nx  = E ? r_pend : (r_rise | (r_pend & ~w_clr));
    w_ovf_nx   = !E && ((r_rise & r_pend & ~w_clr) != 4'b0000);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend  <= 4'b0000;
      r_w     <= 2'b00;
      r_valid <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_pend  <= w_pend_nx;
      r_w     <= w_code_nx;
      r_valid <= w_valid_nx;
      r_ovf   <= w_ovf_nx;
    end
  end

  assign w        = r_w;
  assign valid    = r_valid;
  assign overflow = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_encoder4_2_pending.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_encoder4_2_pending                                                |
// | Scoreboard bench: expected grant codes queued at stimulus time.      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_encoder4_2_pending;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] y = 4'b0000;
  logic       E = 1'b0;
  logic       ready = 1'b0;
  logic [1:0] w;
  logic       valid;
  logic       overflow;

  int n_checks = 0;
  int n_pass   = 0;
  int ovf_cnt  = 0;
  int cyc      = 0;
  int o0;
  int a0;
  int sb[$];
  int acc_t[$];

  encoder4_2_pending #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .y(y), .E(E), .w(w),
    .valid(valid), .ready(ready), .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else n_pass++;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_valid(input string tag, input int max);
    int n = 0;
    while (!valid && n < max) begin
      tick(1);
      n++;
    end
    check(tag, 32'(valid), 32'd1);
  endtask

  // Handshake happens on the coming edge; compare against the scoreboard head.
  always @(negedge clk) begin
    if (overflow) ovf_cnt++;
    if (!rst && valid && ready && !E) begin
      if (sb.size() == 0) check("unexp_grant", 32'(w), 32'hFF);
      else check("grant_w", 32'(w), 32'(sb.pop_front()));
      acc_t.push_back(cyc);
    end
  end

  initial begin
    tick(3);
    check("rst_w", 32'(w), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    rst = 1'b0;
    tick(3);

    // Latency: valid after edge 4, gone after edge 5.
    ready = 1'b1;
    y = 4'b0001;
    sb.push_back(0);
    for (int k = 0; k < 4; k++) begin
      tick(1);
      check("lat_lo", 32'(valid), 32'd0);
    end
    tick(1);
    check("lat_hi", 32'(valid), 32'd1);
    check("lat_w", 32'(w), 32'd0);
    tick(1);
    check("lat_drop", 32'(valid), 32'd0);
    check("lat_pend", 32'(dut.r_pend), 32'd0);
    y = 4'b0000;
    tick(5);

    // Simultaneous requests: priority order, two cycles apart.
    o0 = ovf_cnt;
    y = 4'b1010;
    sb.push_back(3);
    sb.push_back(1);
    tick(15);
    check("pair_gap", 32'(acc_t[acc_t.size()-1] - acc_t[acc_t.size()-2]), 32'd2);
    check("pair_ovf", 32'(ovf_cnt - o0), 32'd0);
    y = 4'b0000;
    tick(5);

    // Higher priority arriving while presenting does not preempt.
    ready = 1'b0;
    y = 4'b0100;
    sb.push_back(2);
    wait_valid("pres_tmo", 20);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) y = 4'b1100;
      tick(1);
      check("pres_w", 32'(w), 32'd2);
      check("pres_v", 32'(valid), 32'd1);
    end
    sb.push_back(3);
    ready = 1'b1;
    tick(20);
    y = 4'b0000;
    tick(5);

    // Double pulse before acceptance: one overflow, one grant.
    ready = 1'b0;
    o0 = ovf_cnt;
    a0 = acc_t.size();
    sb.push_back(0);
    y = 4'b0001; tick(3);
    y = 4'b0000; tick(3);
    y = 4'b0001; tick(3);
    y = 4'b0000; tick(5);
    check("dbl_ovf", 32'(ovf_cnt - o0), 32'd1);
    ready = 1'b1;
    tick(20);
    check("dbl_grants", 32'(acc_t.size() - a0), 32'd1);

    // Disable during presentation; edges while disabled are dropped.
    ready = 1'b0;
    y = 4'b0010;
    sb.push_back(1);
    wait_valid("en_tmo", 20);
    E = 1'b1;
    tick(1);
    check("en_drop", 32'(valid), 32'd0);
    y = 4'b0110;
    tick(8);
    check("en_hold_w", 32'(w), 32'd1);
    E = 1'b0;
    wait_valid("en_re_tmo", 20);
    check("en_re_w", 32'(w), 32'd1);
    ready = 1'b1;
    tick(20);
    y = 4'b0000;
    tick(5);

    // Asynchronous reset mid-presentation; held request granted after release.
    ready = 1'b0;
    y = 4'b0010;
    sb.push_back(1);
    wait_valid("rp_tmo", 20);
    check("rp_w", 32'(w), 32'd1);
    void'(sb.pop_front());
    @(posedge clk);
    #3;
    rst = 1'b1;
    y = 4'b0100;
    #1;
    check("arst_valid", 32'(valid), 32'd0);
    check("arst_w", 32'(w), 32'd0);
    check("arst_pend", 32'(dut.r_pend), 32'd0);
    tick(3);
    rst = 1'b0;
    sb.push_back(2);
    ready = 1'b1;
    tick(20);

    check("sb_drain", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/encoder4_2_pending.md
ENCODER4_2_PENDING -- requirements
Module: encoder4_2_pending

Interface
REQ-001 SHALL have parameter: SYNC_STAGES, default 2, number of synchronizer flops per request line (legal values 2 or 3).
REQ-002 SHALL have port: clk  input  1  single clock; all flops on its rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: y  input  4  asynchronous request lines; bit i requests code i.
REQ-005 SHALL have port: E  input  1  enable, active-low (0 = enabled).
REQ-006 SHALL have port: w  output  2  registered encoded index of the granted request.
REQ-007 SHALL have port: valid  output  1  registered; w holds a valid code.
REQ-008 SHALL have port: ready  input  1  consumer accepts w in any cycle where valid=1 and ready=1.
REQ-009 SHALL have port: overflow  output  1  registered one-cycle pulse on a lost request.

Function
REQ-010 SHALL pass each y[i] through SYNC_STAGES flops, then one delay flop; rising edge = sync_out=1 and delay=0.
REQ-011 SHALL latch a detected rising edge on y[i] into pending[i] only when E=0; edges while E=1 are discarded.
REQ-012 SHALL run a two-state FSM: IDLE, PRESENT.
REQ-013 IDLE: if E=0 and pending!=0, SHALL load w with the index of the highest set pending bit (bit 3 highest priority), set valid=1, go to PRESENT; otherwise valid=0 and w holds.
REQ-014 PRESENT: w and valid SHALL remain stable until a cycle with ready=1 and E=0.
REQ-015 On acceptance (PRESENT, ready=1, E=0) SHALL clear pending[w], drive valid=0 next cycle, return to IDLE.
REQ-016 Throughput SHALL be at most one code per two cycles (one mandatory IDLE cycle between grants).
REQ-017 Latency: with pending empty and FSM in IDLE, valid SHALL rise after rising edge number SYNC_STAGES+2, counting the first edge that samples y[i]=1 as edge 0.
REQ-018 A higher-priority request arriving while PRESENT SHALL NOT change w; priority is evaluated only on the IDLE->PRESENT transition.
REQ-019 ready while IDLE SHALL be ignored.
REQ-020 E rising to 1 while PRESENT SHALL return the FSM to IDLE and force valid=0 next cycle, without clearing pending.
REQ-021 While E=1, w SHALL hold its value, and pending SHALL neither set nor clear.
REQ-022 If a new edge on y[i] coincides with pending[i]=1 and no acceptance clears bit i that cycle, SHALL pulse overflow for one cycle; pending[i] stays 1.
REQ-023 If a new edge on y[i] coincides with acceptance clearing bit i, set SHALL win: pending[i] stays 1, and overflow SHALL NOT pulse.
REQ-024 Edges on different bits in the same cycle SHALL all be latched.
REQ-025 overflow SHALL pulse only when E=0.

Reset
REQ-026 Asserting rst SHALL immediately force the state to IDLE and clear w=2'b00, valid=0, overflow=0, pending=4'b0000, and all synchronizer and delay flops to 0.
REQ-027 A y[i] already high when rst deasserts SHALL be treated as a rising edge, latched per REQ-011.
REQ-028 rst asserted mid-PRESENT SHALL discard the pending code; no acceptance is implied.

Verification
REQ-029 SHALL cover: E=0, SYNC_STAGES=2, y=0001 from edge 0, ready=1 -> valid=1, w=00 after edge 4; valid=0 after edge 5; pending=0.
REQ-030 SHALL cover: y rises to 1010 in one cycle, ready=1 -> w=11 granted first, then w=01 two cycles later; no overflow.
REQ-031 SHALL cover: PRESENT w=10 with ready=0 for 5 cycles, y[3] rises -> w stays 10; after ready=1, next grant is w=11.
REQ-032 SHALL cover: y[0] pulses twice before acceptance -> one overflow pulse; only one w=00 grant.
REQ-033 SHALL cover: E=1 during PRESENT -> valid=0 next cycle; E back to 0 -> same code re-presented; y edges during E=1 are never granted.
REQ-034 SHALL cover: rst asserted asynchronously mid-PRESENT -> valid=0, w=00 before the next clk edge; y held at 0100 through reset -> grant w=10 after release.
